// File: rtl/cs_window_selector.sv
// ---------------------------------------------------------------------------
// cs_window_selector
//
// Sliding-window comparator/selector on an 8-bit unsigned sample stream.
// Every rising edge the current sample X joins the eight previously held
// samples to form a 9-sample window W. From W the block computes:
//   SUM  = sum of W                      (12 bits, max 2295)
//   AVG  = floor(SUM / 9)                (0..255)
//   APPR = largest w in W with w <= AVG  (the "approximate average")
//   Y    = (SUM + 9*APPR) >> 3           (10 bits, max 573, never overflows)
// Y is registered and updates on the same edge that shifts X into the window.
//
// Ports
//   clk    in   1  rising-edge clock, single domain
//   reset  in   1  asynchronous active-low reset; clears history and Y
//   X      in   8  unsigned sample, captured on every rising edge
//   Y      out 10  unsigned registered result
// ---------------------------------------------------------------------------
module cs_window_selector (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  output logic [9:0] Y
);

  localparam int unsigned DW   = 8;   // sample width
  localparam int unsigned NWIN = 9;   // window depth
  localparam int unsigned OW   = 10;  // output width
  localparam int unsigned SW   = 12;  // sum width, holds 9 * 255
  localparam int unsigned TW   = 13;  // SUM + 9*APPR width, holds 4590

  // Only NWIN-1 samples need storage: the newest window element is the live
  // input X. The ninth captured sample would never be read again before it
  // leaves the window, so holding it would be dead state. Index 0 is newest.
  logic [NWIN-2:0][DW-1:0] hist_q;
  logic [NWIN-2:0][DW-1:0] hist_d;

  logic [OW-1:0] y_q;
  logic [OW-1:0] y_d;

  // Full window; element 0 is the current input, element NWIN-1 the oldest.
  logic [NWIN-1:0][DW-1:0] win;

  logic [SW-1:0] sum;
  logic [SW-1:0] avg;
  logic [DW-1:0] appr;
  logic [TW-1:0] tot;

  assign win = {hist_q, X};

  // Shift register next state: new sample enters at the newest slot.
  assign hist_d = {hist_q[NWIN-3:0], X};

  always_comb begin
    sum  = '0;
    appr = '0;

    for (int i = 0; i < NWIN; i++) begin
      sum = sum + SW'(win[i]);
    end

    // Constant divisor; synthesis reduces this to a fixed multiply/shift
    // network rather than a general divider.
    avg = sum / SW'(NWIN);

    // Starting APPR at zero is safe: min(W) <= AVG always holds, so at least
    // one element qualifies and the running max can only rise from there.
    for (int i = 0; i < NWIN; i++) begin
      if ((SW'(win[i]) <= avg) && (win[i] > appr)) begin
        appr = win[i];
      end
    end

    tot = TW'(sum) + (TW'(appr) * TW'(NWIN));
    y_d = OW'(tot >> 3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      y_q    <= '0;
    end else begin
      hist_q <= hist_d;
      y_q    <= y_d;
    end
  end

  // Driven straight from a flop so downstream logic never sees the
  // combinational datapath settling.
  assign Y = y_q;

endmodule

// File: tb/tb_cs_window_selector.sv
// ---------------------------------------------------------------------------
// tb_cs_window_selector
//
// Self-checking bench for cs_window_selector. A reference model keeps the
// last eight captured samples in a plain array and recomputes the expected
// output from the arithmetic definition (sum, integer average, largest sample
// not above the average). Directed sequences cover the documented examples,
// reset behaviour is checked asynchronously, and random streams follow.
// ---------------------------------------------------------------------------
module tb_cs_window_selector;

  logic       clk;
  logic       reset;
  logic [7:0] X;
  logic [9:0] Y;

  int checks;
  int failures;

  // Model history: hist[0] is the most recently captured sample.
  int hist [8];

  cs_window_selector u_dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int model_y(input int x);
    int w [9];
    int sum;
    int avg;
    int appr;
    w[0] = x;
    for (int i = 0; i < 8; i++) w[i+1] = hist[i];
    sum = 0;
    for (int i = 0; i < 9; i++) sum += w[i];
    avg  = sum / 9;
    appr = -1;
    for (int i = 0; i < 9; i++) begin
      if (w[i] <= avg && w[i] > appr) appr = w[i];
    end
    return (sum + 9 * appr) / 8;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endtask

  // Drives one sample, lets one rising edge capture it, then checks Y
  // against the model 1 time unit after the edge.
  task automatic push(input int x, input string tag);
    int exp;
    X   = 8'(x);
    exp = model_y(x);
    @(posedge clk);
    #1;
    check(tag, Y, 10'(exp));
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  task automatic push_n(input int x, input int n, input string tag);
    for (int k = 0; k < n; k++) push(x, tag);
  endtask

  // Asserts reset away from any edge, checks Y clears without a clock,
  // holds it across an edge, then releases away from the edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_now"}, Y, 10'd0);
    @(posedge clk);
    #1;
    check({tag, "_held"}, Y, 10'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  initial begin
    int ramp [10];
    int mixed [9];
    checks   = 0;
    failures = 0;
    X        = 8'd0;
    reset    = 1'b0;
    clear_model();

    #1;
    check("reset_y", Y, 10'd0);
    #20;
    @(negedge clk);
    reset = 1'b1;

    // Constant stream of 9s.
    push_n(9, 9, "const9");
    check("const9_final", Y, 10'd20);

    // Ramp 1..9, then 10.
    for (int i = 0; i < 10; i++) ramp[i] = i + 1;
    for (int i = 0; i < 9; i++) push(ramp[i], "ramp");
    check("ramp_1_9", Y, 10'd11);
    push(ramp[9], "ramp");
    check("ramp_2_10", Y, 10'd13);

    // Maximum values.
    push_n(255, 9, "max");
    check("max_final", Y, 10'd573);

    // Skewed window: eight zeros then 255.
    push_n(0, 8, "skew");
    push(255, "skew");
    check("skew_final", Y, 10'd31);

    // APPR differs from AVG.
    mixed = '{1, 2, 3, 4, 20, 30, 40, 50, 60};
    for (int i = 0; i < 9; i++) push(mixed[i], "mixed");
    check("mixed_final", Y, 10'd48);

    // Mid-stream reset after a full window of large values; no stale sample
    // may leak into the refilled window.
    push_n(200, 9, "pre_rst");
    async_reset("rst_mid");
    push(9, "refill_first");
    push_n(9, 8, "refill");
    check("refill_final", Y, 10'd20);

    // Random streams: full range, then narrow ranges to stress ties.
    for (int k = 0; k < 300; k++) push(int'($urandom_range(0, 255)), "rand_full");
    for (int k = 0; k < 150; k++) push(int'($urandom_range(0, 3)), "rand_small");
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) push(255, "rand_spike");
      else push(int'($urandom_range(0, 20)), "rand_spike");
    end

    async_reset("rst_rand");
    for (int k = 0; k < 100; k++) push(int'($urandom_range(0, 255)), "rand_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
